brent_kung_64bit: RTL and testbench



---
 rtl/brent_kung_64bit.sv | 105 ++++++++++
 tb/tb_brent_kung_64bit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/brent_kung_64bit.sv
// Brent-Kung parallel-prefix adder with registered sum/cout (1-cycle latency).
// Define BK_INPUT_REG_EN to register a/b/cin in front of the prefix tree (2-cycle latency).
module brent_kung_64bit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

`ifdef BK_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
        end else begin
            op_a   <= a;
            op_b   <= b;
            op_cin <= cin;
        end
    end
`else
    assign op_a   = a;
    assign op_b   = b;
    assign op_cin = cin;
`endif

    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_next;
    logic             unused_p;

    assign p_bit = op_a ^ op_b;
    assign g_bit = op_a & op_b;

    // Up-sweep: level k merges each node at 2^k-1 spacing with the node 2^(k-1) below it.
    for (genvar k = 0; k <= LEVELS; k++) begin : up
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        if (k == 0) begin : leaf
            assign g = {g_bit[WIDTH-1:1], g_bit[0] | (p_bit[0] & op_cin)};
            assign p = p_bit;
        end else begin : lvl
            localparam int SPAN = 1 << k;
            localparam int HALF = SPAN / 2;
            for (genvar i = 0; i < WIDTH; i++) begin : node
                if (((i + 1) % SPAN) == 0) begin : merge
                    assign g[i] = up[k-1].g[i] | (up[k-1].p[i] & up[k-1].g[i-HALF]);
                    assign p[i] = up[k-1].p[i] & up[k-1].p[i-HALF];
                end else begin : pass
                    assign g[i] = up[k-1].g[i];
                    assign p[i] = up[k-1].p[i];
                end
            end
        end
    end

    // Down-sweep: fill i = j + 2^(k-1) from completed prefix j, descending k.
    // Node i still holds its up-sweep group [i:j+1], so its propagate comes from the last up level.
    for (genvar s = 0; s < LEVELS; s++) begin : dn
        logic [WIDTH-1:0] g;
        if (s == 0) begin : seed
            assign g = up[LEVELS].g;
        end else begin : lvl
            localparam int K    = LEVELS - s;
            localparam int SPAN = 1 << K;
            localparam int HALF = SPAN / 2;
            for (genvar i = 0; i < WIDTH; i++) begin : node
                localparam int J = i - HALF;
                if ((J >= SPAN - 1) && (((J + 1) % SPAN) == 0)) begin : fill
                    assign g[i] = dn[s-1].g[i] | (up[LEVELS].p[i] & dn[s-1].g[J]);
                end else begin : pass
                    assign g[i] = dn[s-1].g[i];
                end
            end
        end
    end

    assign carry    = dn[LEVELS-1].g;
    assign sum_next = p_bit ^ {carry[WIDTH-2:0], op_cin};
    assign unused_p = ^up[LEVELS].p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= carry[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_brent_kung_64bit.sv
// Scoreboard bench for brent_kung_64bit: driver pushes per-edge expectations, monitor pops and checks.
// Interface has no handshake: a new operand set is accepted on every rising edge (valid always 1, ready always 1).
module tb_brent_kung_64bit;

`ifdef BK_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int W = 65;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] sum;
  logic        cout;

  brent_kung_64bit #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks   = 0;
  int           failures = 0;

  logic         prev_rst = 1'b1;
  logic [W-1:0] prev_res = '0;

  task automatic drive(input logic r, input logic [63:0] av, input logic [63:0] bv,
                       input logic cv, input string nm);
    logic [W-1:0] res;
    logic [W-1:0] expv;
    @(negedge clk);
    rst_n = r;
    a     = av;
    b     = bv;
    cin   = cv;
    @(posedge clk);
    res = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
    if (LAT == 1) expv = !r ? 65'd0 : res;
    else          expv = (!r || prev_rst) ? 65'd0 : prev_res;
    prev_rst = !r;
    prev_res = res;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
          failures++;
          $display("FAIL %s: got cout=%b sum=%h expected cout=%b sum=%h",
                   n, cout, sum, e[64], e[63:0]);
        end
      end
    end
  end

  task automatic drive_rand(input int count, input string nm);
    for (int i = 0; i < count; i++)
      drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), nm);
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '1;
    b     = 64'd1;
    cin   = 1'b0;

    drive(1'b0, '1, 64'd1, 1'b0, "reset0");
    drive(1'b0, '1, 64'd1, 1'b0, "reset1");
    #2;
    checks++;
    if (sum !== 64'd0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got cout=%b sum=%h expected all zero", cout, sum);
    end

    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 64'd0,   64'd0,   1'(c), "zero_zero");
      drive(1'b1, 64'd255, 64'd0,   1'(c), "ff_zero");
      drive(1'b1, 64'd0,   64'd255, 1'(c), "zero_ff");
      drive(1'b1, 64'd255, 64'd255, 1'(c), "ff_ff");
    end

    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, "full_prop");
    drive(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "msb_carry");
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "all_ones");
    drive(1'b1, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, "alt_prop");

    drive_rand(100, "random");

    drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, "mid_reset");
    drive_rand(20, "post_reset");

    drive(1'b0, '0, '0, 1'b0, "zreset");
    drive(1'b1, '0, '0, 1'b0, "zrel0");
    drive(1'b1, '0, '0, 1'b0, "zrel1");
    drive_rand(10, "tail");

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
